// File: rtl/ecc_ctrl_pkg.sv
// Shared types and parameter defaults for the ECC command scheduler and its FIFO.
package ecc_ctrl_pkg;

    localparam int unsigned AMBA_WORD_DEF  = 16;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 2;
    localparam int unsigned TIMEOUT_DEF    = 64;

    typedef enum logic [1:0] {
        ENC     = 2'd0,
        DEC     = 2'd1,
        FULL    = 2'd2,
        ILLEGAL = 2'd3
    } opcode_t;

    typedef enum logic [1:0] {
        CW_8   = 2'd0,
        CW_16  = 2'd1,
        CW_32  = 2'd2,
        CW_BAD = 2'd3
    } cw_width_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_ENC,
        WAIT_ENC,
        ISSUE_DEC,
        WAIT_DEC,
        REPORT
    } sched_state_t;

    typedef struct packed {
        opcode_t                  opcode;
        cw_width_t                width;
        logic [AMBA_WORD_DEF-1:0] data;
        logic [AMBA_WORD_DEF-1:0] noise;
    } ecc_cmd_t;

    function automatic logic cmd_is_legal(input opcode_t op, input cw_width_t w);
        return (op != ILLEGAL) && (w != CW_BAD);
    endfunction

endpackage

// File: rtl/ecc_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module ecc_cmd_fifo
    import ecc_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  ecc_cmd_t din_i,
    input  logic     pop_i,
    output ecc_cmd_t dout_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    ecc_cmd_t        mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ecc_op_scheduler.sv
// Buffers APB-issued ECC commands and runs each over the shared encode/decode datapath,
// chaining encode -> noise XOR -> decode for full-channel commands.
module ecc_op_scheduler
    import ecc_ctrl_pkg::*;
#(
    parameter int unsigned AMBA_WORD  = AMBA_WORD_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] NOISE,
    input  logic                 CTRL_ready,
    output logic                 cmd_accept,
    output logic                 cmd_drop,
    output logic                 busy,
    output logic                 dp_start,
    output logic                 dp_mode,
    output logic [AMBA_WORD-1:0] dp_data,
    output logic [1:0]           dp_width,
    input  logic                 dp_done,
    input  logic [AMBA_WORD-1:0] dp_result,
    input  logic [1:0]           dp_num_err,
    output logic [AMBA_WORD-1:0] data_out,
    output logic                 operation_done,
    output logic [1:0]           num_of_errors,
    output logic                 timeout
);

    localparam int unsigned   TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    ecc_cmd_t             cmd_in;
    ecc_cmd_t             fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 cmd_legal;
    logic                 push;
    logic                 pop;

    sched_state_t         state_q;
    opcode_t              cur_op_q;
    logic [AMBA_WORD-1:0] cur_noise_q;
    logic [TW-1:0]        tmo_cnt_q;

    logic                 cmd_accept_q;
    logic                 cmd_drop_q;
    logic                 dp_start_q;
    logic                 dp_mode_q;
    logic [AMBA_WORD-1:0] dp_data_q;
    logic [1:0]           dp_width_q;
    logic [AMBA_WORD-1:0] data_out_q;
    logic                 op_done_q;
    logic [1:0]           num_err_q;
    logic                 timeout_q;

    logic                 unused_ok;
    assign unused_ok = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2],
                         (DATA_WIDTH > AMBA_WORD)};

    always_comb begin
        cmd_in = '{opcode: opcode_t'(CTRL[1:0]),
                   width:  cw_width_t'(CODEWORD_WIDTH[1:0]),
                   data:   DATA_IN,
                   noise:  NOISE};
    end

    // Fullness is judged before any same-cycle pop, so a push while full is always dropped.
    assign cmd_legal = cmd_is_legal(cmd_in.opcode, cmd_in.width);
    assign push      = CTRL_ready && cmd_legal && !fifo_full;
    assign pop       = (state_q == IDLE) && !fifo_empty;

    ecc_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .din_i   (cmd_in),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_accept_q <= 1'b0;
            cmd_drop_q   <= 1'b0;
        end else begin
            cmd_accept_q <= push;
            cmd_drop_q   <= CTRL_ready && !push;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_op_q    <= ENC;
            cur_noise_q <= '0;
            tmo_cnt_q   <= '0;
            dp_start_q  <= 1'b0;
            dp_mode_q   <= 1'b0;
            dp_data_q   <= '0;
            dp_width_q  <= '0;
            data_out_q  <= '0;
            op_done_q   <= 1'b0;
            num_err_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            dp_start_q <= 1'b0;
            op_done_q  <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur_op_q    <= fifo_head.opcode;
                        cur_noise_q <= fifo_head.noise;
                        dp_data_q   <= fifo_head.data;
                        dp_width_q  <= fifo_head.width;
                        dp_start_q  <= 1'b1;
                        if (fifo_head.opcode == DEC) begin
                            dp_mode_q <= 1'b1;
                            state_q   <= ISSUE_DEC;
                        end else begin
                            dp_mode_q <= 1'b0;
                            state_q   <= ISSUE_ENC;
                        end
                    end
                end
                ISSUE_ENC: begin
                    tmo_cnt_q <= '0;
                    state_q   <= WAIT_ENC;
                end
                ISSUE_DEC: begin
                    tmo_cnt_q <= '0;
                    state_q   <= WAIT_DEC;
                end
                WAIT_ENC: begin
                    if (dp_done) begin
                        if (cur_op_q == FULL) begin
                            // Second leg issues straight from the encode result plus channel noise.
                            dp_data_q  <= dp_result ^ cur_noise_q;
                            dp_mode_q  <= 1'b1;
                            dp_start_q <= 1'b1;
                            state_q    <= ISSUE_DEC;
                        end else begin
                            data_out_q <= dp_result;
                            num_err_q  <= 2'd0;
                            op_done_q  <= 1'b1;
                            state_q    <= REPORT;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        data_out_q <= '0;
                        num_err_q  <= 2'd3;
                        op_done_q  <= 1'b1;
                        timeout_q  <= 1'b1;
                        state_q    <= REPORT;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                WAIT_DEC: begin
                    if (dp_done) begin
                        data_out_q <= dp_result;
                        num_err_q  <= dp_num_err;
                        op_done_q  <= 1'b1;
                        state_q    <= REPORT;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        data_out_q <= '0;
                        num_err_q  <= 2'd3;
                        op_done_q  <= 1'b1;
                        timeout_q  <= 1'b1;
                        state_q    <= REPORT;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                REPORT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy           = !fifo_empty || (state_q != IDLE);
    assign cmd_accept     = cmd_accept_q;
    assign cmd_drop       = cmd_drop_q;
    assign dp_start       = dp_start_q;
    assign dp_mode        = dp_mode_q;
    assign dp_data        = dp_data_q;
    assign dp_width       = dp_width_q;
    assign data_out       = data_out_q;
    assign operation_done = op_done_q;
    assign num_of_errors  = num_err_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_ecc_op_scheduler.sv
// Bench for ecc_op_scheduler: a mock datapath answers dp_start, a command-level model predicts results.
module tb_ecc_op_scheduler;

    localparam int TMO = 64;

    logic        clk;
    logic        reset;
    logic [15:0] CTRL, DATA_IN, CODEWORD_WIDTH, NOISE;
    logic        CTRL_ready;
    logic        cmd_accept, cmd_drop, busy, dp_start, dp_mode;
    logic [15:0] dp_data;
    logic [1:0]  dp_width;
    logic        dp_done;
    logic [15:0] dp_result;
    logic [1:0]  dp_num_err;
    logic [15:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;
    logic        timeout;

    ecc_op_scheduler #(
        .AMBA_WORD  (16),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (2),
        .TIMEOUT    (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .CTRL           (CTRL),
        .DATA_IN        (DATA_IN),
        .CODEWORD_WIDTH (CODEWORD_WIDTH),
        .NOISE          (NOISE),
        .CTRL_ready     (CTRL_ready),
        .cmd_accept     (cmd_accept),
        .cmd_drop       (cmd_drop),
        .busy           (busy),
        .dp_start       (dp_start),
        .dp_mode        (dp_mode),
        .dp_data        (dp_data),
        .dp_width       (dp_width),
        .dp_done        (dp_done),
        .dp_result      (dp_result),
        .dp_num_err     (dp_num_err),
        .data_out       (data_out),
        .operation_done (operation_done),
        .num_of_errors  (num_of_errors),
        .timeout        (timeout)
    );

    typedef struct { int cyc; logic mode; logic [15:0] data; logic [1:0] width; } start_t;
    typedef struct { int cyc; logic [15:0] data; logic [1:0] nerr; logic tmo; } done_t;

    int     cyc;
    int     pass_cnt;
    int     total;
    int     lat;
    bit     mute;
    bit     late_req;
    bit     busy_seen;
    int     stray_tmo;
    int     acc_q[$];
    int     drop_q[$];
    int     dpdone_q[$];
    start_t start_q[$];
    done_t  done_q[$];

    // Stand-in datapath behaviour (not a real ECC code; any fixed mapping will do).
    function automatic logic [15:0] enc_f(input logic [15:0] d);
        return d ^ 16'h0050;
    endfunction
    function automatic logic [15:0] dec_f(input logic [15:0] c);
        return (c ^ 16'h0050) & 16'hFFFB;
    endfunction
    function automatic logic [1:0] nerr_f(input logic [15:0] c);
        return c[8] ? 2'd2 : (c[2] ? 2'd1 : 2'd0);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    // Mock datapath: answers each dp_start after 'lat' cycles unless muted.
    initial begin
        bit          pend;
        int          cnt;
        logic        m;
        logic [15:0] d;
        pend = 0; cnt = 0; m = 1'b0; d = '0;
        dp_done = 1'b0; dp_result = '0; dp_num_err = '0;
        forever begin
            @(negedge clk);
            dp_done = 1'b0;
            if (reset) begin
                pend = 0;
            end else if (dp_start) begin
                pend = !mute;
                cnt  = lat;
                m    = dp_mode;
                d    = dp_data;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend       = 0;
                    dp_done    = 1'b1;
                    dp_result  = m ? dec_f(d) : enc_f(d);
                    dp_num_err = m ? nerr_f(d) : 2'($urandom_range(1, 2));
                    dpdone_q.push_back(cyc);
                end
            end
            if (late_req) begin
                late_req   = 0;
                dp_done    = 1'b1;
                dp_result  = 16'hBEEF;
                dp_num_err = 2'd1;
            end
        end
    end

    initial begin
        busy_seen = 0;
        stray_tmo = 0;
        forever begin
            @(negedge clk);
            if (cmd_accept) acc_q.push_back(cyc);
            if (cmd_drop) drop_q.push_back(cyc);
            if (busy) busy_seen = 1;
            if (dp_start) start_q.push_back('{cyc, dp_mode, dp_data, dp_width});
            if (operation_done) done_q.push_back('{cyc, data_out, num_of_errors, timeout});
            if (timeout && !operation_done) stray_tmo++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete(); drop_q.delete(); dpdone_q.delete();
        start_q.delete(); done_q.delete();
        busy_seen = 0;
    endtask

    task automatic drive(input logic [15:0] c, input logic [15:0] d,
                         input logic [15:0] w, input logic [15:0] n);
        CTRL = c; DATA_IN = d; CODEWORD_WIDTH = w; NOISE = n;
        CTRL_ready = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while ((busy || k < 2) && k < budget);
        if (busy) begin
            total++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, want 0", busy, k);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({cmd_accept, cmd_drop, busy, dp_start, dp_mode, dp_width,
             operation_done, num_of_errors, timeout} !== '0)
            $display("FAIL reset_ctrl: got %b want 0", {cmd_accept, cmd_drop, busy, dp_start,
                     dp_mode, dp_width, operation_done, num_of_errors, timeout});
        else pass_cnt++;
        total++;
        if ({dp_data, data_out} !== 32'h0)
            $display("FAIL reset_data: got %h want 0", {dp_data, data_out});
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_encode();
        int n0;
        clear_logs(); lat = 3;
        tick(); drive(16'h0000, 16'h000A, 16'h0000, 16'hFFFF); n0 = cyc;
        tick(); CTRL_ready = 1'b0;
        wait_idle(100);
        total++;
        if (acc_q.size() != 1 || acc_q[0] != n0 + 1 || drop_q.size() != 0)
            $display("FAIL enc_accept: got %0d accepts/%0d drops, want 1 accept at %0d", acc_q.size(), drop_q.size(), n0 + 1);
        else pass_cnt++;
        total++;
        if (start_q.size() != 1 || start_q[0].cyc != n0 + 2 ||
            {start_q[0].mode, start_q[0].data, start_q[0].width} !== {1'b0, 16'h000A, 2'd0})
            $display("FAIL enc_start: got %0d starts, want one at cycle %0d mode 0 data 000a", start_q.size(), n0 + 2);
        else pass_cnt++;
        total++;
        if (done_q.size() != 1 || dpdone_q.size() != 1 || done_q[0].cyc != n0 + 6 || done_q[0].cyc != dpdone_q[0] + 1)
            $display("FAIL enc_done_cyc: got %0d dones, want one at cycle %0d", done_q.size(), n0 + 6);
        else pass_cnt++;
        total++;
        if ({data_out, num_of_errors, timeout} !== {16'h005A, 2'd0, 1'b0})
            $display("FAIL enc_result: got data=%h nerr=%0d, want 005a/0", data_out, num_of_errors);
        else pass_cnt++;
    endtask

    task automatic test_full_channel();
        int n0;
        clear_logs(); lat = 3;
        tick(); drive(16'h0002, 16'h000A, 16'h0001, 16'h0004); n0 = cyc;
        tick(); CTRL_ready = 1'b0;
        wait_idle(100);
        total++;
        if (start_q.size() != 2 || start_q[1].cyc != n0 + 6 ||
            {start_q[1].mode, start_q[1].data, start_q[1].width} !== {1'b1, 16'h005E, 2'd1})
            $display("FAIL full_dec_start: got %0d starts, want 2nd at %0d mode 1 data 005e w 1", start_q.size(), n0 + 6);
        else pass_cnt++;
        total++;
        if (done_q.size() != 1 || done_q[0].cyc != n0 + 10 ||
            {done_q[0].data, done_q[0].nerr} !== {16'h000A, 2'd1})
            $display("FAIL full_result: got %0d dones data=%h nerr=%0d, want 000a/1 at %0d", done_q.size(), data_out, num_of_errors, n0 + 10);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int          n0, na;
        logic [15:0] exp [3];
        clear_logs(); lat = 15;
        tick(); drive(16'h0000, 16'h0011, 16'h0000, 16'h0000); n0 = cyc;
        tick(); CTRL_ready = 1'b0;
        tick(); tick();
        drive(16'h0001, 16'h0123, 16'h0002, 16'h0000); na = cyc;
        tick(); drive(16'h0000, 16'h00FF, 16'h0000, 16'h0000);
        tick(); drive(16'h0001, 16'h7777, 16'h0000, 16'h0000);
        tick(); CTRL_ready = 1'b0;
        wait_idle(300);
        total++;
        if (acc_q.size() != 3 || acc_q[1] != na + 1 || acc_q[2] != na + 2 ||
            drop_q.size() != 1 || drop_q[0] != na + 3)
            $display("FAIL ovf_accept: got %0d accepts/%0d drops, want 3/1 (drop at %0d)", acc_q.size(), drop_q.size(), na + 3);
        else pass_cnt++;
        exp[0] = enc_f(16'h0011); exp[1] = dec_f(16'h0123); exp[2] = enc_f(16'h00FF);
        total++;
        if (done_q.size() != 3 || done_q[0].data !== exp[0] || done_q[1].data !== exp[1] ||
            done_q[2].data !== exp[2] || done_q[1].nerr !== nerr_f(16'h0123))
            $display("FAIL ovf_order: got %0d dones, want %h %h %h in order", done_q.size(), exp[0], exp[1], exp[2]);
        else pass_cnt++;
        total++;
        if (start_q.size() != 3 || start_q[1].cyc < done_q[0].cyc + 2 || start_q[2].cyc < done_q[1].cyc + 2)
            $display("FAIL b2b_gap: got %0d starts, want each >=2 cycles after previous done", start_q.size());
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        int n0, n1;
        clear_logs(); lat = 3;
        tick(); drive(16'h0003, 16'h0055, 16'h0000, 16'h0000); n0 = cyc;
        tick(); CTRL_ready = 1'b0;
        tick(); drive(16'h0000, 16'h0055, 16'h0003, 16'h0000); n1 = cyc;
        tick(); CTRL_ready = 1'b0;
        repeat (6) tick();
        total++;
        if (drop_q.size() != 2 || drop_q[0] != n0 + 1 || drop_q[1] != n1 + 1 || acc_q.size() != 0)
            $display("FAIL illegal_drop: got %0d drops/%0d accepts, want 2/0", drop_q.size(), acc_q.size());
        else pass_cnt++;
        total++;
        if (start_q.size() != 0 || busy_seen)
            $display("FAIL illegal_idle: got %0d starts busy_seen=%0b, want 0/0", start_q.size(), busy_seen);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 3; i++) begin
            logic [15:0] c, d;
            logic        exp_tmo;
            int          s;
            clear_logs();
            mute = (i == 0);
            lat  = (i == 1) ? TMO : TMO + 1;
            c    = (i == 2) ? 16'h0000 : 16'h0001;
            d    = 16'h1234 + 16'(i);
            exp_tmo = (i != 1);
            tick(); drive(c, d, 16'h0000, 16'h0000);
            tick(); CTRL_ready = 1'b0;
            wait_idle(200);
            s = (start_q.size() > 0) ? start_q[0].cyc : -1000;
            total++;
            if (done_q.size() != 1 || done_q[0].cyc != s + TMO + 1 || done_q[0].tmo !== exp_tmo)
                $display("FAIL tmo_cyc_%0d: got %0d dones (tmo=%0b), want one at %0d tmo=%0b", i, done_q.size(), timeout, s + TMO + 1, exp_tmo);
            else pass_cnt++;
            total++;
            if (exp_tmo && {data_out, num_of_errors} !== {16'h0000, 2'd3})
                $display("FAIL tmo_value_%0d: got %h/%0d, want 0000/3", i, data_out, num_of_errors);
            else if (!exp_tmo && {data_out, num_of_errors} !== {dec_f(d), nerr_f(d)})
                $display("FAIL tmo_edge_%0d: got %h/%0d, want %h/%0d", i, data_out, num_of_errors, dec_f(d), nerr_f(d));
            else pass_cnt++;
        end
        mute = 0;
        total++;
        if (stray_tmo != 0)
            $display("FAIL tmo_stray: got %0d timeout pulses without operation_done, want 0", stray_tmo);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        clear_logs(); mute = 1; lat = 3;
        tick(); drive(16'h0001, 16'h0033, 16'h0002, 16'h0000);
        tick(); CTRL_ready = 1'b0;
        tick(); drive(16'h0000, 16'h0044, 16'h0000, 16'h0000);
        tick(); CTRL_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        total++;
        if ({cmd_accept, cmd_drop, busy, dp_start, dp_mode, dp_width, dp_data,
             data_out, operation_done, num_of_errors, timeout} !== '0)
            $display("FAIL rst_mid_zero: got busy=%0b mode=%0b data=%h out=%h nerr=%0d, want all 0",
                     busy, dp_mode, dp_data, data_out, num_of_errors);
        else pass_cnt++;
        reset = 1'b0;
        mute = 0;
        late_req = 1;
        repeat (12) tick();
        total++;
        if (done_q.size() != 0 || start_q.size() != 1 || acc_q.size() != 2 || busy)
            $display("FAIL rst_mid_flush: got %0d dones %0d starts busy=%0b, want 0/1/0", done_q.size(), start_q.size(), busy);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            logic [1:0]  op, w;
            logic [15:0] d, n, ld;
            logic        legal;
            int          n0, ns;
            logic        em [2];
            logic [15:0] ed [2];
            clear_logs();
            op  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            w   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            d   = 16'($urandom);
            n   = 16'($urandom);
            lat = $urandom_range(1, 10);
            legal = (op != 2'd3) && (w != 2'd3);
            ns = (op == 2'd2) ? 2 : 1;
            em[0] = (op == 2'd1); ed[0] = d;
            em[1] = 1'b1;         ed[1] = enc_f(d) ^ n;
            ld = ed[ns - 1];
            tick(); drive({14'($urandom), op}, d, {14'($urandom), w}, n); n0 = cyc;
            tick(); CTRL_ready = 1'b0;
            wait_idle(200);
            total++;
            if (legal && (acc_q.size() != 1 || acc_q[0] != n0 + 1 || drop_q.size() != 0))
                $display("FAIL rnd_accept_%0d: got %0d accepts, want 1 at %0d", it, acc_q.size(), n0 + 1);
            else if (!legal && (drop_q.size() != 1 || drop_q[0] != n0 + 1 || acc_q.size() != 0))
                $display("FAIL rnd_drop_%0d: got %0d drops, want 1 at %0d", it, drop_q.size(), n0 + 1);
            else pass_cnt++;
            total++;
            if (start_q.size() != (legal ? ns : 0) || (legal && start_q[0].cyc != n0 + 2))
                $display("FAIL rnd_starts_%0d: got %0d starts, want %0d", it, start_q.size(), legal ? ns : 0);
            else pass_cnt++;
            if (legal && start_q.size() == ns) begin
                for (int k = 0; k < ns; k++) begin
                    total++;
                    if ({start_q[k].mode, start_q[k].data, start_q[k].width} !== {em[k], ed[k], w})
                        $display("FAIL rnd_op_%0d_%0d: got %b/%h/%0d, want %b/%h/%0d", it, k,
                                 start_q[k].mode, start_q[k].data, start_q[k].width, em[k], ed[k], w);
                    else pass_cnt++;
                end
            end
            total++;
            if (!legal && done_q.size() != 0)
                $display("FAIL rnd_nodone_%0d: got %0d dones, want 0", it, done_q.size());
            else if (legal && (done_q.size() != 1 || dpdone_q.size() != ns ||
                     done_q[0].cyc != dpdone_q[ns - 1] + 1 || done_q[0].tmo !== 1'b0 ||
                     {done_q[0].data, done_q[0].nerr} !==
                     ((op == 2'd0) ? {enc_f(d), 2'd0} : {dec_f(ld), nerr_f(ld)})))
                $display("FAIL rnd_result_%0d: got %0d dones data=%h nerr=%0d", it, done_q.size(), data_out, num_of_errors);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0; total = 0;
        lat = 3; mute = 0; late_req = 0;
        reset = 1'b1; CTRL_ready = 1'b0;
        CTRL = '0; DATA_IN = '0; CODEWORD_WIDTH = '0; NOISE = '0;
        test_reset();
        test_encode();
        test_full_channel();
        test_overflow();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
